inv_subbytes_ctrl: RTL and testbench

INV_SUBBYTES_CTRL -- requirements
Module: inv_subbytes_ctrl

---
 rtl/inv_subbytes_ctrl.sv | 150 +++++++++++++++
 tb/tb_inv_subbytes_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/inv_subbytes_ctrl.sv
// inv_subbytes_ctrl
//   Sequences one 128-bit cipher state through a shared, registered inverse
//   S-box one byte per cycle. A state is accepted in IDLE, its 16 bytes are
//   issued in ISSUE (byte 0 first), the last S-box result is collected in
//   DRAIN, and the substituted state is presented in DONE until taken.
//
//   Byte order: byte 0 is bits [127:120], byte 15 is bits [7:0], for both
//   state_in and state_out.
//
// Ports
//   clk, reset        clock (rising edge), async active-low reset
//   in_valid/in_ready input handshake, state_in carries the state
//   out_valid/out_ready output handshake, state_out carries the result
//   sbox_valid/addr   issue side of the shared registered inverse S-box
//   sbox_dout         S-box result, valid one cycle after an issue
//   busy              high whenever the FSM is not IDLE
//   abort             (ISB_ABORT_EN only) drops the current operation
//
// Configuration
//   ISB_ABORT_EN      when defined, adds the abort input. abort=1 outside IDLE
//                     returns the FSM to IDLE at the next edge with no result;
//                     it wins over out_ready in DONE. Undefined by default.

module inv_subbytes_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         sbox_valid,
  output logic [7:0]   sbox_addr,
  input  logic [7:0]   sbox_dout,
  output logic         busy
`ifdef ISB_ABORT_EN
  ,
  input  logic         abort
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  // Packed as [15:0][7:0] so element 15 is bits [127:120]: byte k lives in
  // element 15-k, which for a 4-bit index is simply ~k.
  logic [15:0][7:0]  in_q;
  logic [15:0][7:0]  res_q;
  logic [3:0]        cnt_nxt;
  logic [3:0]        cnt_prv;
  logic              abort_hit;

  assign cnt_nxt   = cnt + 4'd1;
  assign cnt_prv   = cnt - 4'd1;
  assign state_out = res_q;

`ifdef ISB_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // All handshake and S-box outputs are flops that move with the state, so
  // reset forces every one of them (including in_ready) to 0. in_ready comes
  // up on the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      in_q       <= '0;
      res_q      <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      sbox_valid <= 1'b0;
      sbox_addr  <= 8'h00;
    end else if (abort_hit) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      sbox_valid <= 1'b0;
      sbox_addr  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_q       <= state_in;
            cnt        <= 4'd0;
            state      <= ISSUE;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            // First issue goes out straight from the input bus since in_q is
            // only being loaded on this same edge.
            sbox_valid <= 1'b1;
            sbox_addr  <= state_in[127:120];
          end
        end
        ISSUE: begin
          // S-box is one cycle behind the issue: the result arriving now
          // belongs to the byte issued with cnt-1.
          if (cnt != 4'd0) res_q[~cnt_prv] <= sbox_dout;
          if (cnt == 4'd15) begin
            state      <= DRAIN;
            cnt        <= 4'd0;
            sbox_valid <= 1'b0;
            sbox_addr  <= 8'h00;
          end else begin
            cnt        <= cnt_nxt;
            sbox_addr  <= in_q[~cnt_nxt];
          end
        end
        DRAIN: begin
          res_q[0]  <= sbox_dout;
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          // Going back to IDLE here does not accept new input this cycle;
          // the next handshake can happen in IDLE at the following edge.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= 4'd0;
          in_ready   <= 1'b0;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
          sbox_valid <= 1'b0;
          sbox_addr  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_subbytes_ctrl.sv
// Directed bench for inv_subbytes_ctrl with a registered inverse S-box model.
module tb_inv_subbytes_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] state_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] state_out;
  logic         sbox_valid;
  logic [7:0]   sbox_addr;
  logic [7:0]   sbox_dout = 8'h00;
  logic         busy;
`ifdef ISB_ABORT_EN
  logic         abort = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  localparam logic [127:0] V1_IN  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V1_EXP = 128'h52096ad53036a538bf40a39e81f3d7fb;
  localparam logic [127:0] V63    = {16{8'h63}};
  localparam logic [127:0] VFF    = {16{8'hff}};
  localparam logic [127:0] V7D    = {16{8'h7d}};

  inv_subbytes_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .state_in   (state_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .state_out  (state_out),
    .sbox_valid (sbox_valid),
    .sbox_addr  (sbox_addr),
    .sbox_dout  (sbox_dout),
    .busy       (busy)
`ifdef ISB_ABORT_EN
    ,
    .abort      (abort)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inverse AES S-box, one 16-entry row per element, entry 0 in the top byte.
  logic [127:0] inv_rows [16] = '{
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sb(input logic [7:0] a);
    logic [127:0] r;
    int           col;
    r   = inv_rows[a[7:4]];
    col = 15 - int'(a[3:0]);
    return r[8*col +: 8];
  endfunction

  // Registered S-box: result one cycle after an issue with valid high.
  always @(posedge clk) if (sbox_valid) sbox_dout <= inv_sb(sbox_addr);

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one state from the current IDLE cycle: handshake, latency count,
  // optional hold in DONE with out_ready low, result check, release.
  task automatic run_state(input string tag, input logic [127:0] din,
                           input logic [127:0] exp, input int hold);
    int n;
    in_valid = 1'b1;
    state_in = din;
    step();
    in_valid = 1'b0;
    n = 1;
    chk({tag, "_issue0_valid"}, 128'(sbox_valid), 128'(1'b1));
    chk({tag, "_issue0_addr"}, 128'(sbox_addr), 128'(din[127:120]));
    while (!out_valid && n < 40) begin
      step();
      n++;
      if (n == 17) chk({tag, "_drain_sbox_valid"}, 128'(sbox_valid), 128'(1'b0));
    end
    chk({tag, "_latency"}, 128'(n), 128'(18));
    chk({tag, "_result"}, state_out, exp);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_out_valid"}, 128'(out_valid), 128'(1'b1));
      chk({tag, "_hold_state_out"}, state_out, exp);
      chk({tag, "_hold_in_ready"}, 128'(in_ready), 128'(1'b0));
      chk({tag, "_hold_sbox_valid"}, 128'(sbox_valid), 128'(1'b0));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_released"}, 128'({out_valid, in_ready, busy}), 128'(3'b010));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int t1;
    int t2;
    #2 reset = 1'b0;
    step();
    step();
    chk("rst_in_ready", 128'(in_ready), 128'(1'b0));
    chk("rst_outs", 128'({out_valid, busy, sbox_valid, sbox_addr}), 128'(0));
    chk("rst_state_out", state_out, 128'(0));
    @(negedge clk) reset = 1'b1;
    step();
    chk("rel_in_ready", 128'(in_ready), 128'(1'b1));

    run_state("v1", V1_IN, V1_EXP, 5);
    run_state("v63", V63, 128'(0), 0);
    run_state("vff", VFF, V7D, 0);

    // in_valid held through busy with a different state on the bus, then
    // back-to-back completion with out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = V1_IN;
    step();
    state_in = VFF;
    n = 0;
    while (!out_valid && n < 40) begin
      if (n == 3) chk("b2b_in_ready_busy", 128'(in_ready), 128'(1'b0));
      step();
      n++;
    end
    t1 = cyc;
    chk("b2b_first_result", state_out, V1_EXP);
    step();
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    t2 = cyc;
    in_valid = 1'b0;
    chk("b2b_spacing", 128'(t2 - t1), 128'(19));
    chk("b2b_second_result", state_out, V7D);
    step();
    out_ready = 1'b0;
    chk("b2b_idle", 128'(busy), 128'(1'b0));

    // Reset in the middle of ISSUE at cnt=7.
    in_valid = 1'b1;
    state_in = V1_IN;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    chk("mid_cnt7_addr", 128'(sbox_addr), 128'(8'h07));
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_flags", 128'({in_ready, out_valid, busy, sbox_valid}), 128'(0));
    chk("mid_rst_addr", 128'(sbox_addr), 128'(0));
    chk("mid_rst_state_out", state_out, 128'(0));
    @(negedge clk) reset = 1'b1;
    step();
    chk("mid_rel_in_ready", 128'(in_ready), 128'(1'b1));
    n = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) n++;
      step();
    end
    chk("mid_no_out_valid", 128'(n), 128'(0));

`ifdef ISB_ABORT_EN
    in_valid = 1'b1;
    state_in = V63;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    chk("abort_cnt10_addr", 128'(sbox_addr), 128'(8'h63));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", 128'({busy, in_ready, sbox_valid, out_valid}), 128'(4'b0100));
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) n++;
      step();
    end
    chk("abort_no_out_valid", 128'(n), 128'(0));
    run_state("post_abort", V1_IN, V1_EXP, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
